// File: rtl/mbgd_ram_arbiter.sv
// -----------------------------------------------------------------------------
// mbgd_ram_arbiter
//
// Shares the single-port synchronous MBGD data RAM between the APB register
// file (port A) and the MBGD compute engine (port B). One access is granted
// per cycle. Grants are combinational and use strict round-robin under
// contention. Read data is returned one cycle later to the port that issued
// the read.
//
// Ports
//   apb_pclk, resetn         clock / asynchronous active-low reset
//   a_req, a_rd, a_addr,     port A request, read(1)/write(0), address,
//   a_wdata                  write data (held stable until a_gnt)
//   a_gnt                    port A access accepted this cycle
//   a_rvalid, a_rdata        port A read return (data held after rvalid drops)
//   b_*                      same set for port B
//   RAM_CS, RAM_RD,          RAM control bus driven from the granted port,
//   RAM_Addr, RAM_dataIn     all zero when no port is granted
//   RAM_dataOut              RAM read data, valid the cycle after CS&RD
//   last_owner               owner of the most recent grant (0 = A, 1 = B)
//   conflict_cnt             saturating count of cycles with a_req && b_req
// -----------------------------------------------------------------------------
module mbgd_ram_arbiter #(
   parameter int ADDR  = 8,
   parameter int DATA  = 8,
   parameter int CNT_W = 8
) (
   input  logic             apb_pclk,
   input  logic             resetn,
   input  logic             a_req,
   input  logic             a_rd,
   input  logic [ADDR-1:0]  a_addr,
   input  logic [DATA-1:0]  a_wdata,
   output logic             a_gnt,
   output logic             a_rvalid,
   output logic [DATA-1:0]  a_rdata,
   input  logic             b_req,
   input  logic             b_rd,
   input  logic [ADDR-1:0]  b_addr,
   input  logic [DATA-1:0]  b_wdata,
   output logic             b_gnt,
   output logic             b_rvalid,
   output logic [DATA-1:0]  b_rdata,
   output logic             RAM_CS,
   output logic             RAM_RD,
   output logic [ADDR-1:0]  RAM_Addr,
   output logic [DATA-1:0]  RAM_dataIn,
   input  logic [DATA-1:0]  RAM_dataOut,
   output logic             last_owner,
   output logic [CNT_W-1:0] conflict_cnt
);

   // Read-return pipeline: vld_p1 marks a read issued last cycle,
   // owner_p1 says which port issued it (0 = A, 1 = B).
   logic            vld_p1;
   logic            owner_p1;
   logic [DATA-1:0] a_hold_p1;
   logic [DATA-1:0] b_hold_p1;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}})
         return v;
      else
         return v + 1'b1;
   endfunction

   // Grant and RAM bus mux (stage p0, combinational).
   // Grants are forced low while reset is asserted so the RAM bus is
   // quiet immediately, even if a requester still holds its request.
   always_comb begin
      a_gnt      = 1'b0;
      b_gnt      = 1'b0;
      RAM_RD     = 1'b0;
      RAM_Addr   = '0;
      RAM_dataIn = '0;
      if (resetn) begin
         if (a_req && b_req) begin
            // Strict round-robin: the port that did not win last time wins.
            a_gnt = last_owner;
            b_gnt = ~last_owner;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
      // Only the granted port's fields reach the bus, so X on an idle
      // port's fields cannot leak out.
      if (a_gnt) begin
         RAM_RD     = a_rd;
         RAM_Addr   = a_addr;
         RAM_dataIn = a_wdata;
      end else if (b_gnt) begin
         RAM_RD     = b_rd;
         RAM_Addr   = b_addr;
         RAM_dataIn = b_wdata;
      end
   end

   assign RAM_CS = a_gnt | b_gnt;

   // Stage p0 -> p1 boundary: owner history, contention count, read tag.
   always_ff @(posedge apb_pclk or negedge resetn) begin
      if (!resetn) begin
         last_owner   <= 1'b1;
         conflict_cnt <= '0;
         vld_p1       <= 1'b0;
         owner_p1     <= 1'b0;
      end else begin
         if (RAM_CS)
            last_owner <= b_gnt;
         if (a_req && b_req)
            conflict_cnt <= sat_inc(conflict_cnt);
         vld_p1   <= RAM_CS & RAM_RD;
         owner_p1 <= b_gnt;
      end
   end

   // Stage p1: read return. The holding registers keep the last returned
   // word visible after rvalid drops.
   assign a_rvalid = vld_p1 & ~owner_p1;
   assign b_rvalid = vld_p1 &  owner_p1;
   assign a_rdata  = a_rvalid ? RAM_dataOut : a_hold_p1;
   assign b_rdata  = b_rvalid ? RAM_dataOut : b_hold_p1;

   always_ff @(posedge apb_pclk or negedge resetn) begin
      if (!resetn) begin
         a_hold_p1 <= '0;
         b_hold_p1 <= '0;
      end else begin
         if (a_rvalid)
            a_hold_p1 <= RAM_dataOut;
         if (b_rvalid)
            b_hold_p1 <= RAM_dataOut;
      end
   end

endmodule

// File: tb/tb_mbgd_ram_arbiter.sv
module tb_mbgd_ram_arbiter;

   localparam int ADDR  = 8;
   localparam int DATA  = 8;
   localparam int CNT_W = 8;

   logic             apb_pclk = 1'b0;
   logic             resetn   = 1'b0;
   logic             a_req, a_rd, b_req, b_rd;
   logic [ADDR-1:0]  a_addr, b_addr;
   logic [DATA-1:0]  a_wdata, b_wdata;
   logic             a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DATA-1:0]  a_rdata, b_rdata;
   logic             RAM_CS, RAM_RD;
   logic [ADDR-1:0]  RAM_Addr;
   logic [DATA-1:0]  RAM_dataIn;
   logic [DATA-1:0]  RAM_dataOut = '0;
   logic             last_owner;
   logic [CNT_W-1:0] conflict_cnt;

   int tests  = 0;
   int failed = 0;

   always #5 apb_pclk = ~apb_pclk;

   mbgd_ram_arbiter #(.ADDR(ADDR), .DATA(DATA), .CNT_W(CNT_W)) dut (
      .apb_pclk(apb_pclk), .resetn(resetn),
      .a_req(a_req), .a_rd(a_rd), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_rd(b_rd), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .RAM_CS(RAM_CS), .RAM_RD(RAM_RD), .RAM_Addr(RAM_Addr),
      .RAM_dataIn(RAM_dataIn), .RAM_dataOut(RAM_dataOut),
      .last_owner(last_owner), .conflict_cnt(conflict_cnt)
   );

   // Behavioural single-port synchronous RAM.
   logic [DATA-1:0] mem [0:(1<<ADDR)-1];
   initial for (int i = 0; i < (1<<ADDR); i++) mem[i] = '0;
   always @(posedge apb_pclk) begin
      if (RAM_CS) begin
         if (RAM_RD) RAM_dataOut <= mem[RAM_Addr];
         else        mem[RAM_Addr] <= RAM_dataIn;
      end
   end

   typedef struct {
      logic ar, ard; logic [7:0] aad, awd;
      logic br, brd; logic [7:0] bad, bwd;
      logic e_ag, e_bg, e_cs, e_rd; logic [7:0] e_addr, e_din;
      logic e_arv, e_brv; logic [7:0] e_ard, e_brd;
      logic e_lo;
   } vec_t;

   vec_t vt[$];

   task automatic add(input logic ar, ard, input logic [7:0] aad, awd,
                      input logic br, brd, input logic [7:0] bad, bwd,
                      input logic ag, bg, cs, rd, input logic [7:0] addr, din,
                      input logic arv, brv, input logic [7:0] ard_e, brd_e,
                      input logic lo);
      vec_t v;
      v.ar = ar; v.ard = ard; v.aad = aad; v.awd = awd;
      v.br = br; v.brd = brd; v.bad = bad; v.bwd = bwd;
      v.e_ag = ag; v.e_bg = bg; v.e_cs = cs; v.e_rd = rd;
      v.e_addr = addr; v.e_din = din;
      v.e_arv = arv; v.e_brv = brv; v.e_ard = ard_e; v.e_brd = brd_e;
      v.e_lo = lo;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      a_req = 0; a_rd = 'x; a_addr = 'x; a_wdata = 'x;
      b_req = 0; b_rd = 'x; b_addr = 'x; b_wdata = 'x;
   endtask

   task automatic next_cycle();
      @(posedge apb_pclk); #1;
   endtask

   task automatic do_reset();
      resetn = 0;
      idle_inputs();
      repeat (2) @(posedge apb_pclk);
      #1 resetn = 1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      // Table: hand-computed grant / bus / read-return per cycle after reset.
      //   A: req rd addr wdata    B: req rd addr wdata    ag bg cs rd addr din  arv brv ardata brdata lo
      add(1,0,8'h10,8'h5A, 1,1,8'h20,8'h00, 1,0,1,0,8'h10,8'h5A, 0,0,8'h00,8'h00, 1);
      add(0,'x,'x,'x,      1,1,8'h10,8'h33, 0,1,1,1,8'h10,8'h33, 0,0,8'h00,8'h00, 0);
      add(0,'x,'x,'x,      0,'x,'x,'x,      0,0,0,0,8'h00,8'h00, 0,1,8'h00,8'h5A, 1);
      add(1,0,8'h21,8'h11, 1,0,8'h22,8'h22, 1,0,1,0,8'h21,8'h11, 0,0,8'h00,8'h5A, 1);
      add(1,0,8'h23,8'h33, 1,0,8'h22,8'h22, 0,1,1,0,8'h22,8'h22, 0,0,8'h00,8'h5A, 0);
      add(1,0,8'h23,8'h33, 0,'x,'x,'x,      1,0,1,0,8'h23,8'h33, 0,0,8'h00,8'h5A, 1);
      add(1,1,8'h22,8'h00, 1,1,8'h21,8'h00, 0,1,1,1,8'h21,8'h00, 0,0,8'h00,8'h5A, 0);
      add(1,1,8'h22,8'h00, 0,'x,'x,'x,      1,0,1,1,8'h22,8'h00, 0,1,8'h00,8'h11, 1);
      add(0,'x,'x,'x,      0,'x,'x,'x,      0,0,0,0,8'h00,8'h00, 1,0,8'h22,8'h11, 0);
      add(0,'x,'x,'x,      0,'x,'x,'x,      0,0,0,0,8'h00,8'h00, 0,0,8'h22,8'h11, 0);

      // Reset state.
      do_reset();
      @(negedge apb_pclk);
      chk("rst_a_gnt", a_gnt, 0);        chk("rst_b_gnt", b_gnt, 0);
      chk("rst_a_rvalid", a_rvalid, 0);  chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);    chk("rst_b_rdata", b_rdata, 0);
      chk("rst_cs", RAM_CS, 0);          chk("rst_rd", RAM_RD, 0);
      chk("rst_addr", RAM_Addr, 0);      chk("rst_din", RAM_dataIn, 0);
      chk("rst_last_owner", last_owner, 1);
      chk("rst_conflict_cnt", conflict_cnt, 0);
      next_cycle();

      // Table-driven vectors.
      for (int i = 0; i < vt.size(); i++) begin
         v = vt[i];
         a_req = v.ar; a_rd = v.ard; a_addr = v.aad; a_wdata = v.awd;
         b_req = v.br; b_rd = v.brd; b_addr = v.bad; b_wdata = v.bwd;
         @(negedge apb_pclk);
         chk($sformatf("v%0d_a_gnt", i), a_gnt, v.e_ag);
         chk($sformatf("v%0d_b_gnt", i), b_gnt, v.e_bg);
         chk($sformatf("v%0d_cs", i), RAM_CS, v.e_cs);
         chk($sformatf("v%0d_rd", i), RAM_RD, v.e_rd);
         chk($sformatf("v%0d_addr", i), RAM_Addr, v.e_addr);
         chk($sformatf("v%0d_din", i), RAM_dataIn, v.e_din);
         chk($sformatf("v%0d_a_rvalid", i), a_rvalid, v.e_arv);
         chk($sformatf("v%0d_b_rvalid", i), b_rvalid, v.e_brv);
         chk($sformatf("v%0d_a_rdata", i), a_rdata, v.e_ard);
         chk($sformatf("v%0d_b_rdata", i), b_rdata, v.e_brd);
         chk($sformatf("v%0d_last_owner", i), last_owner, v.e_lo);
         next_cycle();
      end
      chk("table_conflict_cnt", conflict_cnt, 4);

      // Continuous contention, both reading: A,B,A,B... with returns routed.
      do_reset();
      a_req = 1; a_rd = 1; a_addr = 8'h22; a_wdata = 8'h00;
      b_req = 1; b_rd = 1; b_addr = 8'h21; b_wdata = 8'h00;
      for (int k = 0; k < 8; k++) begin
         @(negedge apb_pclk);
         chk($sformatf("rr%0d_a_gnt", k), a_gnt, (k % 2 == 0));
         chk($sformatf("rr%0d_b_gnt", k), b_gnt, (k % 2 == 1));
         if (k > 0) begin
            chk($sformatf("rr%0d_a_rvalid", k), a_rvalid, (k % 2 == 1));
            chk($sformatf("rr%0d_b_rvalid", k), b_rvalid, (k % 2 == 0));
            if (k % 2 == 1) chk($sformatf("rr%0d_a_rdata", k), a_rdata, 8'h22);
            else            chk($sformatf("rr%0d_b_rdata", k), b_rdata, 8'h11);
         end
         next_cycle();
      end
      idle_inputs();
      @(negedge apb_pclk);
      chk("rr_last_b_rvalid", b_rvalid, 1);
      chk("rr_last_b_rdata", b_rdata, 8'h11);
      chk("rr_conflict_cnt", conflict_cnt, 8);
      next_cycle();

      // Saturation of the contention counter.
      a_req = 1; a_rd = 0; a_addr = 8'h40; a_wdata = 8'h01;
      b_req = 1; b_rd = 0; b_addr = 8'h41; b_wdata = 8'h02;
      repeat (300) next_cycle();
      idle_inputs();
      @(negedge apb_pclk);
      chk("sat_conflict_cnt", conflict_cnt, 255);
      next_cycle();

      // Single requester with continuous request is granted every cycle.
      do_reset();
      b_req = 1; b_rd = 0; b_addr = 8'h50; b_wdata = 8'h77;
      for (int k = 0; k < 4; k++) begin
         @(negedge apb_pclk);
         chk($sformatf("solo%0d_b_gnt", k), b_gnt, 1);
         chk($sformatf("solo%0d_a_gnt", k), a_gnt, 0);
         next_cycle();
      end
      idle_inputs();
      @(negedge apb_pclk);
      chk("solo_conflict_cnt", conflict_cnt, 0);
      next_cycle();

      // Reset in the cycle after a granted A read.
      do_reset();
      a_req = 1; a_rd = 1; a_addr = 8'h22; a_wdata = 8'h00;
      @(negedge apb_pclk);
      chk("mid_a_gnt", a_gnt, 1);
      @(posedge apb_pclk);
      #2 resetn = 0;
      #1;
      chk("mid_a_rvalid", a_rvalid, 0);
      chk("mid_cs", RAM_CS, 0);
      chk("mid_last_owner", last_owner, 1);
      chk("mid_a_rdata", a_rdata, 0);
      idle_inputs();
      @(posedge apb_pclk);
      #1 resetn = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge apb_pclk);
         chk($sformatf("post%0d_a_rvalid", k), a_rvalid, 0);
         chk($sformatf("post%0d_b_rvalid", k), b_rvalid, 0);
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
